// File: rtl/key_schedule_ctrl.sv
// ============================================================================
// key_schedule_ctrl : AES key expansion into a round-key store, with round-key read port
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module key_schedule_ctrl_sbox4 (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // Inverse as a^254 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end

endmodule

module key_schedule_ctrl #(
  parameter int Nk = 4,
  parameter int nr = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [0:32*Nk-1]  key,
  output logic              busy,
  output logic              done,
  input  logic              rk_req,
  input  logic [3:0]        rk_round,
  output logic              rk_valid,
  output logic [0:127]      rk_data,
  output logic              rk_err
);

  localparam int         NW        = 4 * (nr + 1);
  localparam logic [5:0] c_nk      = 6'(Nk);
  localparam logic [5:0] c_last    = 6'(NW - 1);
  localparam logic [3:0] c_nr      = 4'(nr);
  localparam logic [2:0] c_mod_max = 3'(Nk - 1);
  localparam bit         c_nk_big  = (Nk > 6);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_i;
  logic [2:0]  r_imod;
  logic [7:0]  r_rcon;
  logic        r_done;
  logic        r_rk_valid;
  logic        r_rk_err;
  logic [0:127] r_rk_data;
  logic [31:0] r_w [0:NW-1];

  logic        w_load;
  logic        w_last;
  logic [31:0] w_prev;
  logic [31:0] w_far;
  logic [31:0] w_sb_in;
  logic [31:0] w_sb_out;
  logic [31:0] w_temp;
  logic [5:0]  w_base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    w_load  = start && (r_state != S_EXPAND);
    w_last  = (r_i == c_last);
    w_prev  = r_w[r_i - 6'd1];
    w_far   = r_w[r_i - c_nk];
    w_sb_in = (r_imod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_temp  = w_prev;
    if (r_imod == 3'd0)
      w_temp = w_sb_out ^ {r_rcon, 24'h000000};
    else if (c_nk_big && (r_imod == 3'd4))
      w_temp = w_sb_out;
    w_base  = {rk_round, 2'b00};
  end

  key_schedule_ctrl_sbox4 u_sbox (
    .i_word (w_sb_in),
    .o_word (w_sb_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_READY: if (start) w_state_nxt = S_EXPAND;
      S_EXPAND:        if (w_last) w_state_nxt = S_READY;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= 6'd0;
      r_imod  <= 3'd0;
      r_rcon  <= 8'h01;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_EXPAND) && w_last;
      if (w_load) begin
        r_i    <= c_nk;
        r_imod <= 3'd0;
        r_rcon <= 8'h01;
      end else if (r_state == S_EXPAND) begin
        r_i    <= r_i + 6'd1;
        r_imod <= (r_imod == c_mod_max) ? 3'd0 : r_imod + 3'd1;
        if (r_imod == 3'd0) r_rcon <= xtime(r_rcon);
      end
    end
  end

  // Word store carries no reset; validity is tracked by the state machine.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int j = 0; j < Nk; j++) r_w[j] <= key[32*j +: 32];
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_far ^ w_temp;
    end
  end

  // Reads sample the store before any same-edge restart overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      r_rk_data  <= '0;
    end else if (rk_req) begin
      if ((r_state == S_READY) && (rk_round <= c_nr)) begin
        r_rk_valid <= 1'b1;
        r_rk_err   <= 1'b0;
        r_rk_data  <= {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
      end else begin
        r_rk_valid <= 1'b0;
        r_rk_err   <= 1'b1;
      end
    end else begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
    end
  end

  assign busy     = (r_state == S_EXPAND);
  assign done     = r_done;
  assign rk_valid = r_rk_valid;
  assign rk_err   = r_rk_err;
  assign rk_data  = r_rk_data;

endmodule

`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
// ============================================================================
// tb_key_schedule_ctrl : directed checks of key_schedule_ctrl (AES-128 and AES-256)
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key;
  logic         busy, done, rk_req, rk_valid, rk_err;
  logic [3:0]   rk_round;
  logic [0:127] rk_data;

  logic         start2;
  logic [0:255] key2;
  logic         busy2, done2, rk_req2, rk_valid2, rk_err2;
  logic [3:0]   rk_round2;
  logic [0:127] rk_data2;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  logic [127:0] exp128 [0:10];

  always #5 clk = ~clk;

  key_schedule_ctrl #(.Nk(4), .nr(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy), .done(done),
    .rk_req(rk_req), .rk_round(rk_round), .rk_valid(rk_valid), .rk_data(rk_data), .rk_err(rk_err)
  );

  key_schedule_ctrl #(.Nk(8), .nr(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start2), .key(key2), .busy(busy2), .done(done2),
    .rk_req(rk_req2), .rk_round(rk_round2), .rk_valid(rk_valid2), .rk_data(rk_data2), .rk_err(rk_err2)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready128();
    while (busy && cnt < 200) begin
      step();
      if (busy) cnt++;
    end
  endtask

  initial begin
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0; start = 1'b0; rk_req = 1'b0; rk_round = 4'd0;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start2 = 1'b0; rk_req2 = 1'b0; rk_round2 = 4'd0;
    key2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    step(); step();
    check_val("rst_busy",  busy,     0);
    check_val("rst_done",  done,     0);
    check_val("rst_valid", rk_valid, 0);
    check_val("rst_err",   rk_err,   0);
    check_val("rst_data",  rk_data,  0);
    rst_n = 1'b1;
    step();

    rk_req = 1'b1; rk_round = 4'd0;
    step();
    rk_req = 1'b0;
    check_val("idle_read_err",   rk_err,   1);
    check_val("idle_read_valid", rk_valid, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    cnt = 1;
    rk_req = 1'b1; rk_round = 4'd0;
    step();
    rk_req = 1'b0;
    if (busy) cnt++;
    check_val("expand_read_err",   rk_err,   1);
    check_val("expand_read_valid", rk_valid, 0);
    check_val("expand_read_data",  rk_data,  0);
    wait_ready128();
    check_val("busy_cycles_128", cnt,  40);
    check_val("done_pulse",      done, 1);
    step();
    check_val("done_one_cycle",  done, 0);

    rk_req = 1'b1; rk_round = 4'd11;
    step();
    rk_req = 1'b0;
    check_val("round11_err",   rk_err,   1);
    check_val("round11_valid", rk_valid, 0);

    rk_req = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      rk_round = 4'(r);
      step();
      check_val($sformatf("stream_valid_%0d", r), rk_valid, 1);
      check_val($sformatf("stream_data_%0d", r),  rk_data,  exp128[r]);
    end
    rk_req = 1'b0;
    step();
    check_val("hold_valid", rk_valid, 0);
    check_val("hold_data",  rk_data,  exp128[10]);

    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cnt = busy2 ? 1 : 0;
    while (busy2 && cnt < 200) begin
      step();
      if (busy2) cnt++;
    end
    check_val("busy_cycles_256", cnt,   52);
    check_val("done_256",        done2, 1);
    rk_req2 = 1'b1; rk_round2 = 4'd14;
    step();
    check_val("r14_256", rk_data2, 128'hfe4890d1e6188d0b046df344706c631e);
    rk_round2 = 4'd0;
    step();
    rk_req2 = 1'b0;
    check_val("r0_256", rk_data2, 128'h603deb1015ca71be2b73aef0857d7781);

    key = '0; start = 1'b1; rk_req = 1'b1; rk_round = 4'd10;
    step();
    start = 1'b0; rk_req = 1'b0;
    check_val("restart_old_valid", rk_valid, 1);
    check_val("restart_old_data",  rk_data,  exp128[10]);
    check_val("restart_busy",      busy,     1);
    cnt = 1;
    rk_req = 1'b1; rk_round = 4'd0;
    step();
    rk_req = 1'b0;
    if (busy) cnt++;
    check_val("restart_read_err", rk_err, 1);
    wait_ready128();
    check_val("busy_cycles_restart", cnt, 40);
    rk_req = 1'b1; rk_round = 4'd1;
    step();
    check_val("zero_key_r1", rk_data, 128'h62636363626363636263636362636363);
    rk_round = 4'd10;
    step();
    rk_req = 1'b0;
    check_val("zero_key_r10", rk_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    key = 128'h2b7e151628aed2a6abf7158809cf4f3c; start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    check_val("busy_before_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy",  busy,     0);
    check_val("arst_done",  done,     0);
    check_val("arst_valid", rk_valid, 0);
    check_val("arst_err",   rk_err,   0);
    check_val("arst_data",  rk_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    rk_req = 1'b1; rk_round = 4'd0;
    step();
    rk_req = 1'b0;
    check_val("post_rst_err",   rk_err,   1);
    check_val("post_rst_valid", rk_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have parameter Nk, default 4, giving the key length in 32-bit words (4, 6 or 8).
REQ-002 The block SHALL have parameter nr, default 10, giving the number of rounds (10, 12 or 14, matching Nk).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to load key and run the expansion.
REQ-006 The block SHALL have port key, input, [0:32*Nk-1]: the cipher key, where key[0:31] is word w[0] (big-endian, bit 0 = MSB).
REQ-007 The block SHALL have port busy, output, 1 bit: high while the expansion is running.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the schedule becomes complete.
REQ-009 The block SHALL have port rk_req, input, 1 bit: a round-key read request.
REQ-010 The block SHALL have port rk_round, input, [3:0]: the round index requested.
REQ-011 The block SHALL have port rk_valid, output, 1 bit: rk_data is valid in this cycle.
REQ-012 The block SHALL have port rk_data, output, [0:127]: the round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-013 The block SHALL have port rk_err, output, 1 bit: a one-cycle pulse flagging a rejected read request.

Function
REQ-014 The block SHALL implement states IDLE, EXPAND and READY, held in a word store of 4*(nr+1) 32-bit entries.
REQ-015 When start=1 in IDLE or READY, the block SHALL, on that edge, write key into w[0..Nk-1], set i=Nk and the Rcon register to 8'h01, and go to EXPAND.
REQ-016 In EXPAND the block SHALL compute and write exactly one word w[i] per cycle, as w[i] = w[i-Nk] ^ temp, where temp = w[i-1].
REQ-017 When i mod Nk = 0, temp SHALL be SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}, after which Rcon advances by xtime (8'h80 -> 8'h1b).
REQ-018 When Nk>6 and i mod Nk = 4, temp SHALL be SubWord(w[i-1]) with no Rcon applied.
REQ-019 The block SHALL use a single 4-byte AES S-box instance for all SubWord operations, with i mod Nk tracked by a wrapping counter rather than a divider.
REQ-020 The last word, w[4*(nr+1)-1], SHALL be written 4*(nr+1)-Nk edges after the start edge (40 for Nk=4, nr=10), with the state going to READY on that same edge.
REQ-021 busy SHALL be 1 exactly while in EXPAND.
REQ-022 done SHALL be 1 exactly for the first cycle in READY.
REQ-023 start=1 during EXPAND SHALL be ignored.
REQ-024 start=1 in READY SHALL restart the expansion: the old keys are invalid from that edge on, and reads during the new expansion are rejected.
REQ-025 rk_req=1 in READY with rk_round<=nr SHALL produce rk_valid=1 and rk_data = round key rk_round on the next cycle (latency 1); back-to-back requests SHALL be served every cycle.
REQ-026 rk_req=1 in IDLE or EXPAND, or with rk_round>nr, SHALL produce rk_err=1 and rk_valid=0 on the next cycle, with rk_data unchanged.
REQ-027 If rk_req and start are both 1 in READY on the same edge, the read SHALL be served from the old keys and the restart SHALL take effect on that edge.
REQ-028 rk_data SHALL hold its last value when rk_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, rk_valid=0, rk_err=0, rk_data=0, i=0, Rcon=8'h01.
REQ-030 Reset during EXPAND SHALL abort the expansion; a read after release SHALL give rk_err until a new start completes.
REQ-031 The word store SHALL not need a reset.

Verification
REQ-032 AES-128 vector: Nk=4, nr=10, key=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> busy for 40 cycles, then done; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 AES-256 vector: Nk=8, nr=14, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-034 Error reads: rk_req during EXPAND, and rk_round=11 in READY with nr=10 -> rk_err pulse, rk_valid=0.
REQ-035 Restart: start in READY with a new key, concurrent with rk_req for round 10 -> old round-10 key returned; after 40 cycles, the new keys are readable.
REQ-036 Reset: rst_n low at cycle 20 of EXPAND -> all outputs are 0 immediately; a round-0 read after release -> rk_err.
REQ-037 Streaming: rk_req held high for rounds 0..10 in consecutive cycles -> rk_valid high for 11 consecutive cycles, with the correct keys in order.
